dram_bridge: RTL and testbench

Data-side memory responder sitting between the MEM stage's `dram_*` initiator port and the on-chip data bus. It accepts one load or store per instruction and holds the pipeline with `dram_wait` until the bus completes it. It returns load data for exactly one un-stalled cycle, applies fixed kseg0/kseg1 address mapping, and flags bus hangs with a watchdog.

---
 rtl/dram_bridge_pkg.sv | 27 ++
 rtl/dram_bridge.sv | 94 +++++++++
 tb/tb_dram_bridge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_bridge_pkg.sv
// Shared types and constants for the data-side DRAM bridge.
// Provides bus widths, FSM encodings and the kseg0/kseg1 address fold.
package dram_bridge_pkg;

  typedef logic [31:0] AddrBus;
  typedef logic [31:0] DataBus;
  typedef logic [3:0]  WriteEn;

  localparam DataBus ZeroWord  = 32'h0000_0000;
  localparam WriteEn WrDisable = 4'b0000;
  localparam AddrBus KSEG_MASK = 32'h1FFF_FFFF;

  typedef enum logic [1:0] {
    DB_IDLE = 2'd0,
    DB_REQ  = 2'd1,
    DB_RESP = 2'd2,
    DB_DONE = 2'd3
  } db_state_t;

  // kseg0/kseg1 fold onto the low 512 MiB; the bus only ever sees word addresses
  function automatic AddrBus map_addr(input AddrBus va);
    AddrBus phys;
    phys = (va[31:30] == 2'b10) ? (va & KSEG_MASK) : va;
    return {phys[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dram_bridge.sv
// MEM-stage data port to on-chip bus: one bus transaction per access, 3 cycles minimum (2 stalled + DONE).
// Backpressure: dram_wait holds MEM from the request cycle until the bus response; a watchdog flags hangs.
import dram_bridge_pkg::*;

module dram_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dram_en,
  input  logic [31:0] dram_addr,
  input  logic [3:0]  dram_wen,
  input  logic [31:0] dram_wdata,
  output logic [31:0] dram_rdata,
  output logic        dram_wait,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  db_state_t  state_q, state_d;
  DataBus     rdata_q;
  logic [7:0] wd_cnt_q;
  logic [7:0] wd_cnt_inc;
  logic       busy;
  logic       capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DB_IDLE: if (dram_en)    state_d = DB_REQ;
      DB_REQ:  if (bus_gnt)    state_d = bus_rvalid ? DB_DONE : DB_RESP;
      DB_RESP: if (bus_rvalid) state_d = DB_DONE;
      DB_DONE:                 state_d = DB_IDLE;
      default:                 state_d = DB_IDLE;
    endcase
  end

  always_comb begin
    bus_req    = (state_q == DB_REQ);
    dram_wait  = ((state_q == DB_IDLE) && dram_en) || (state_q == DB_REQ) || (state_q == DB_RESP);
    dram_rdata = (state_q == DB_DONE) ? rdata_q : ZeroWord;
  end

  assign busy    = (state_q == DB_REQ) || (state_q == DB_RESP);
  assign capture = ((state_q == DB_REQ) && bus_gnt && bus_rvalid) ||
                   ((state_q == DB_RESP) && bus_rvalid);

  // Request fields are frozen for the whole bus transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_addr  <= ZeroWord;
      bus_wstrb <= WrDisable;
      bus_wdata <= ZeroWord;
    end else if ((state_q == DB_IDLE) && dram_en) begin
      bus_addr  <= map_addr(dram_addr);
      bus_wstrb <= dram_wen;
      bus_wdata <= dram_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdata_q <= ZeroWord;
    else if (capture) rdata_q <= (bus_wstrb == WrDisable) ? bus_rdata : ZeroWord;
  end

  assign wd_cnt_inc = (wd_cnt_q == 8'hFF) ? wd_cnt_q : wd_cnt_q + 8'd1;

  // Flag rises on the edge that completes the TIMEOUT-th busy cycle; the access keeps waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= 8'd0;
      bus_err  <= 1'b0;
    end else if (busy) begin
      wd_cnt_q <= wd_cnt_inc;
      if (wd_cnt_inc >= TMO) bus_err <= 1'b1;
    end else begin
      wd_cnt_q <= 8'd0;
    end
  end

endmodule

// File: tb/tb_dram_bridge.sv
// Randomized bench for dram_bridge: a bus responder with chosen grant/response delays
// and a transaction-level model of address mapping, stall length, load data and watchdog.
module tb_dram_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dram_en;
  logic [31:0] dram_addr;
  logic [3:0]  dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic        dram_wait;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_done;
  logic err_exp;

  dram_bridge #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .dram_en    (dram_en),
    .dram_addr  (dram_addr),
    .dram_wen   (dram_wen),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .dram_wait  (dram_wait),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upper 1 GiB window starting at 0x8000_0000 aliases the bottom 512 MiB
  function automatic logic [31:0] model_addr(input logic [31:0] a);
    logic [31:0] p;
    if (a >= 32'h8000_0000 && a < 32'hC000_0000) p = a % 32'h2000_0000;
    else                                         p = a;
    return p - (p % 4);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(bus_req),   0);
    chk({tag, "_wait"},  32'(dram_wait), 0);
    chk({tag, "_addr"},  bus_addr,       0);
    chk({tag, "_wstrb"}, 32'(bus_wstrb), 0);
    chk({tag, "_wdata"}, bus_wdata,      0);
    chk({tag, "_rdata"}, dram_rdata,     0);
    chk({tag, "_err"},   32'(bus_err),   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    dram_en = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dram_en    = 1'b0;
      bus_gnt    = 1'($urandom);
      bus_rvalid = 1'($urandom);
      bus_rdata  = $urandom;
      #1;
      chk("idle_wait",  32'(dram_wait), 0);
      chk("idle_req",   32'(bus_req),   0);
      chk("idle_rdata", dram_rdata,     0);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  // One access: grant on the (g+1)-th request cycle, response r cycles after grant
  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd,
                        input int g, input int r, input logic [31:0] rd);
    int phase, reqs, hs, stall, rcnt, finished;
    logic req;
    logic [31:0] exp_ba;
    exp_ba = model_addr(a);
    phase = 0; reqs = 0; hs = 0; stall = 0; rcnt = 0; finished = 0; busy_done = 0;
    for (int cyc = 0; cyc < 64 && finished == 0; cyc++) begin
      @(negedge clk);
      req        = bus_req;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      if (cyc == 0) begin
        dram_en = 1'b1; dram_addr = a; dram_wen = w; dram_wdata = wd;
        bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom);
      end else if (phase == 0) begin
        if (req) begin
          reqs++;
          if (reqs == g + 1) begin
            bus_gnt = 1'b1;
            if (r == 0) begin bus_rvalid = 1'b1; bus_rdata = rd; phase = 2; end
            else phase = 1;
          end
        end
      end else if (phase == 1) begin
        rcnt++;
        bus_gnt = 1'($urandom);
        if (rcnt == r) begin bus_rvalid = 1'b1; bus_rdata = rd; phase = 2; end
      end else begin
        bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom);
      end
      if (req && bus_gnt) hs++;
      #1;
      if (busy_done >= TMO) err_exp = 1'b1;
      chk("bus_err", 32'(bus_err), 32'(err_exp));
      if (dram_wait) begin
        stall++;
        chk("rdata_stalled", dram_rdata, 0);
        if (cyc > 0) begin
          busy_done++;
          chk("bus_addr",  bus_addr,       exp_ba);
          chk("bus_wstrb", 32'(bus_wstrb), 32'(w));
          chk("bus_wdata", bus_wdata,      wd);
        end
      end else begin
        finished = 1;
        chk("done_rdata", dram_rdata, (w == 4'b0000) ? rd : 32'h0);
        chk("stall_cycles", stall, 1 + (g + 1) + r);
        chk("handshakes", hs, 1);
        chk("req_cycles", reqs, g + 1);
      end
    end
    chk("access_done", finished, 1);
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic watchdog_test();
    busy_done = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (cyc == 0) begin
        dram_en = 1'b1; dram_addr = 32'h1000_0040; dram_wen = 4'b0000; dram_wdata = 32'h0;
      end
      #1;
      if (busy_done >= TMO) err_exp = 1'b1;
      chk("wd_err", 32'(bus_err), 32'(err_exp));
      chk("wd_wait", 32'(dram_wait), 1);
      if (cyc > 0) begin
        chk("wd_req", 32'(bus_req), 1);
        busy_done++;
      end
    end
    chk("wd_err_final", 32'(bus_err), 1);
  endtask

  task automatic midop_reset_test();
    @(negedge clk);
    dram_en = 1'b1; dram_addr = 32'h8000_0100; dram_wen = 4'b0000; dram_wdata = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk("mid_req", 32'(bus_req), 1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    chk("mid_resp_wait", 32'(dram_wait), 1);
    chk("mid_resp_req",  32'(bus_req),   0);
    #2;
    rst = 1'b1; dram_en = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0; err_exp = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    chk("stray_req",   32'(bus_req),   0);
    chk("stray_wait",  32'(dram_wait), 0);
    chk("stray_rdata", dram_rdata,     0);
  endtask

  initial begin
    rst = 1'b1; dram_en = 1'b0; dram_addr = '0; dram_wen = '0; dram_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    err_exp = 1'b0; busy_done = 0;
    #12;
    check_reset_outputs("init");
    @(negedge clk);
    rst = 1'b0;

    access(32'h8000_1234, 4'b0000, 32'h0,         0, 0, 32'hCAFE_BABE);
    idle_cycles(1);
    access(32'hA000_0010, 4'b1100, 32'hABCD_0000, 3, 2, 32'h1234_5678);
    do_reset();
    access(32'h0040_0008, 4'b1111, 32'h0BAD_F00D, 0, 0, 32'h7777_7777);
    access(32'h0040_0000, 4'b0000, 32'h0,         0, 0, 32'h600D_CAFE);
    access(32'h8000_0003, 4'b0000, 32'h0,         0, 1, 32'hDEAD_BEEF);
    do_reset();

    for (int t = 0; t < 40; t++) begin
      logic [3:0] w;
      w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      access($urandom, w, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
      if (t % 10 == 9) do_reset();
    end

    do_reset();
    watchdog_test();
    do_reset();
    midop_reset_test();
    access(32'hBFFF_FFFC, 4'b0000, 32'h0, 1, 0, 32'h0102_0304);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
